// File: rtl/board_row_fetch.sv
// board_row_fetch
//   Fetches one board row (BOARD_WIDTH cells) from the synchronous board RAM,
//   one cell per cycle, into a shadow buffer. It then commits the whole row to
//   Row in a single cycle, so the colour mapper never sees a half-updated row.
//
// Ports
//   Clk, reset      : system clock (rising edge), async active-high reset
//   LD_Row, rowNum  : single-cycle load request and the row to fetch
//   ram_addr/ram_rd : RAM read address and strobe (data one cycle later)
//   ram_q           : RAM read data
//   Row             : committed row, indexed by column
//   rowReady        : one-cycle pulse after Row has been updated
//   busy            : a fetch is accepted, pending or in flight
module board_row_fetch #(
    parameter int BOARD_WIDTH  = 10,
    parameter int BOARD_HEIGHT = 20,
    parameter int CELL_W       = 16
) (
    input  logic                                Clk,
    input  logic                                reset,
    input  logic                                LD_Row,
    input  logic [7:0]                          rowNum,
    output logic [7:0]                          ram_addr,
    output logic                                ram_rd,
    input  logic [CELL_W-1:0]                   ram_q,
    output logic [BOARD_WIDTH-1:0][CELL_W-1:0]  Row,
    output logic                                rowReady,
    output logic                                busy
);
    localparam int COL_W = $clog2(BOARD_WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] READ   = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic [1:0]                         state_q, state_d;
    logic [COL_W-1:0]                   col_q, col_d;
    logic [7:0]                         req_row_q, req_row_d;
    logic                               pend_valid_q, pend_valid_d;
    logic [7:0]                         pend_row_q, pend_row_d;
    logic                               cap_valid_q, cap_valid_d;
    logic [COL_W-1:0]                   cap_col_q, cap_col_d;
    logic                               cap_zero_q, cap_zero_d;
    logic [BOARD_WIDTH-1:0][CELL_W-1:0] shadow_q, shadow_d;
    logic [BOARD_WIDTH-1:0][CELL_W-1:0] row_q, row_d;
    logic                               row_ready_q, row_ready_d;

    logic       req_oob;
    logic [7:0] base;

    // row*10 as (row*8 + row*2); max address 199 fits in 8 bits.
    assign req_oob = (req_row_q >= 8'(BOARD_HEIGHT));
    assign base    = (req_row_q << 3) + (req_row_q << 1);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        req_row_d    = req_row_q;
        pend_valid_d = pend_valid_q;
        pend_row_d   = pend_row_q;
        row_d        = row_q;
        shadow_d     = shadow_q;

        // Requests outside IDLE (including the COMMIT cycle) park here;
        // a newer one simply overwrites the older.
        if (LD_Row && state_q != IDLE) begin
            pend_valid_d = 1'b1;
            pend_row_d   = rowNum;
        end

        case (state_q)
            IDLE: begin
                col_d = '0;
                if (LD_Row) begin
                    req_row_d    = rowNum;
                    pend_valid_d = 1'b0;
                    state_d      = READ;
                end else if (pend_valid_q) begin
                    req_row_d    = pend_row_q;
                    pend_valid_d = 1'b0;
                    state_d      = READ;
                end
            end
            READ: begin
                col_d = col_q + 1'b1;
                if (col_q == COL_W'(BOARD_WIDTH - 1))
                    state_d = DRAIN;
            end
            DRAIN:  state_d = COMMIT;
            COMMIT: begin
                row_d   = shadow_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Capture pipeline: the word for a read issued this cycle arrives next
        // cycle and is written on the edge after that. Out-of-range rows
        // issue no reads and fill the shadow with black instead.
        cap_valid_d = (state_q == READ);
        cap_col_d   = col_q;
        cap_zero_d  = req_oob;
        if (cap_valid_q)
            shadow_d[cap_col_q] = cap_zero_q ? '0 : ram_q;

        row_ready_d = (state_q == COMMIT);
    end

    always_comb begin
        ram_rd   = 1'b0;
        ram_addr = '0;
        if (state_q == READ && !req_oob) begin
            ram_rd   = 1'b1;
            ram_addr = base + 8'(col_q);
        end
    end

    assign Row      = row_q;
    assign rowReady = row_ready_q;
    assign busy     = (state_q != IDLE) || pend_valid_q;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            req_row_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_row_q   <= '0;
            cap_valid_q  <= 1'b0;
            cap_col_q    <= '0;
            cap_zero_q   <= 1'b0;
            shadow_q     <= '0;
            row_q        <= '0;
            row_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            req_row_q    <= req_row_d;
            pend_valid_q <= pend_valid_d;
            pend_row_q   <= pend_row_d;
            cap_valid_q  <= cap_valid_d;
            cap_col_q    <= cap_col_d;
            cap_zero_q   <= cap_zero_d;
            shadow_q     <= shadow_d;
            row_q        <= row_d;
            row_ready_q  <= row_ready_d;
        end
    end
endmodule

// File: tb/tb_board_row_fetch.sv
module tb_board_row_fetch;
    typedef logic [9:0][15:0] row_t;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        LD_Row = 1'b0;
    logic [7:0]  rowNum = '0;
    logic [7:0]  ram_addr;
    logic        ram_rd;
    logic [15:0] ram_q = '0;
    row_t        Row;
    logic        rowReady;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    row_t       sb_q[$];
    logic [7:0] obs_addr[$];
    int         obs_ready[$];
    row_t       obs_rows[$];
    int         busy_cnt;

    board_row_fetch dut (
        .Clk(Clk), .reset(reset), .LD_Row(LD_Row), .rowNum(rowNum),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
        .Row(Row), .rowReady(rowReady), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Board RAM model: cell content = address, data one cycle after strobe.
    always @(posedge Clk) if (ram_rd) ram_q <= {8'h00, ram_addr};

    function automatic row_t make_row(input int r);
        row_t x = '0;
        if (r < 20) for (int k = 0; k < 10; k++) x[k] = 16'(r * 10 + k);
        return x;
    endfunction

    task automatic pulse(input logic [7:0] r);
        @(negedge Clk);
        LD_Row = 1'b1;
        rowNum = r;
    endtask

    // Records what the DUT does for ncyc cycles after a pulse; cycle n is the
    // n-th falling edge after the sampling edge. Optional extra pulses.
    task automatic observe(input int ncyc, input int p2_n, input logic [7:0] p2_r,
                           input int p3_n, input logic [7:0] p3_r);
        obs_addr.delete(); obs_ready.delete(); obs_rows.delete(); busy_cnt = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge Clk);
            LD_Row = 1'b0;
            if (ram_rd) obs_addr.push_back(ram_addr);
            if (rowReady) begin obs_ready.push_back(n); obs_rows.push_back(Row); end
            if (busy) busy_cnt++;
            if (n == p2_n) begin LD_Row = 1'b1; rowNum = p2_r; end
            if (n == p3_n) begin LD_Row = 1'b1; rowNum = p3_r; end
        end
        LD_Row = 1'b0;
    endtask

    task automatic test_reset;
        int bad = 0;
        reset = 1'b1;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (Row !== '0 || rowReady !== 1'b0 || ram_rd !== 1'b0 || busy !== 1'b0 || ram_addr !== 8'd0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL reset_idle: %0d bad cycles, required 0 (Row=%h rr=%b rd=%b busy=%b)", bad, Row, rowReady, ram_rd, busy);
        end
    endtask

    task automatic check_single(input string nm, input int r);
        int nrd = (r < 20) ? 10 : 0;
        row_t exp;
        vectors++;
        if (obs_addr.size() !== nrd) begin
            miscompares++;
            $display("FAIL %s_rd_count: got %0d, required %0d", nm, obs_addr.size(), nrd);
        end
        for (int i = 0; i < obs_addr.size() && i < nrd; i++) begin
            vectors++;
            if (obs_addr[i] !== 8'(r * 10 + i)) begin
                miscompares++;
                $display("FAIL %s_addr[%0d]: got %0d, required %0d", nm, i, obs_addr[i], r * 10 + i);
            end
        end
        vectors++;
        if (obs_ready.size() !== 1 || obs_ready[0] !== 13) begin
            miscompares++;
            $display("FAIL %s_ready: %0d pulses first at %0d, required 1 at 13", nm, obs_ready.size(),
                     obs_ready.size() > 0 ? obs_ready[0] : -1);
        end
        vectors++;
        if (busy_cnt !== 12) begin
            miscompares++;
            $display("FAIL %s_busy: %0d cycles, required 12", nm, busy_cnt);
        end
        if (obs_rows.size() > 0 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            vectors++;
            if (obs_rows[0] !== exp) begin
                miscompares++;
                $display("FAIL %s_row: got %h, required %h", nm, obs_rows[0], exp);
            end
            vectors++;
            if (Row !== exp) begin
                miscompares++;
                $display("FAIL %s_row_hold: got %h, required %h", nm, Row, exp);
            end
        end
    endtask

    task automatic test_row3;
        sb_q.push_back(make_row(3));
        pulse(8'd3);
        observe(16, -1, 8'd0, -1, 8'd0);
        check_single("row3", 3);
    endtask

    task automatic test_edge_rows;
        sb_q.push_back(make_row(19));
        pulse(8'd19);
        observe(16, -1, 8'd0, -1, 8'd0);
        check_single("row19", 19);
        sb_q.push_back(make_row(25));
        pulse(8'd25);
        observe(16, -1, 8'd0, -1, 8'd0);
        check_single("row25", 25);
    endtask

    task automatic check_pair(input string nm, input int ra, input int rb);
        row_t exp;
        vectors++;
        if (obs_addr.size() !== 20) begin
            miscompares++;
            $display("FAIL %s_rd_count: got %0d, required 20", nm, obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 20; i++) begin
            int ea = (i < 10) ? ra * 10 + i : rb * 10 + i - 10;
            vectors++;
            if (obs_addr[i] !== 8'(ea)) begin
                miscompares++;
                $display("FAIL %s_addr[%0d]: got %0d, required %0d", nm, i, obs_addr[i], ea);
            end
        end
        vectors++;
        if (obs_ready.size() !== 2 || obs_ready[0] !== 13 || obs_ready[1] !== 26) begin
            miscompares++;
            $display("FAIL %s_ready: %0d pulses at %0d/%0d, required 2 at 13/26", nm, obs_ready.size(),
                     obs_ready.size() > 0 ? obs_ready[0] : -1, obs_ready.size() > 1 ? obs_ready[1] : -1);
        end
        for (int i = 0; i < obs_rows.size() && sb_q.size() > 0; i++) begin
            exp = sb_q.pop_front();
            vectors++;
            if (obs_rows[i] !== exp) begin
                miscompares++;
                $display("FAIL %s_row%0d: got %h, required %h", nm, i, obs_rows[i], exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        sb_q.push_back(make_row(2));
        sb_q.push_back(make_row(7));
        pulse(8'd2);
        observe(30, 4, 8'd5, 6, 8'd7);
        check_pair("pending", 2, 7);
    endtask

    task automatic test_commit_overlap;
        sb_q.push_back(make_row(6));
        sb_q.push_back(make_row(8));
        pulse(8'd6);
        observe(30, 12, 8'd8, -1, 8'd0);
        check_pair("commit_req", 6, 8);
    endtask

    task automatic test_reset_mid;
        pulse(8'd4);
        observe(6, -1, 8'd0, -1, 8'd0);
        reset = 1'b1;
        #1;
        vectors++;
        if (Row !== '0 || rowReady !== 1'b0 || ram_rd !== 1'b0 || busy !== 1'b0 || ram_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_now: Row=%h rr=%b rd=%b busy=%b addr=%0d, required all 0",
                     Row, rowReady, ram_rd, busy, ram_addr);
        end
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        observe(16, -1, 8'd0, -1, 8'd0);
        vectors++;
        if (obs_ready.size() !== 0 || Row !== '0 || obs_addr.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_after: %0d ready pulses, %0d reads, Row=%h, required 0/0/0",
                     obs_ready.size(), obs_addr.size(), Row);
        end
    endtask

    initial begin
        test_reset();
        test_row3();
        test_edge_rows();
        test_back_to_back();
        test_reset_mid();
        test_commit_overlap();
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d rows left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
